// File: rtl/uart_bus_pkg.sv
// Shared types for the UART polled-I/O bus master.
// Holds the FSM state enum, register offsets and the bus request bundle.
package uart_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        STAT,
        DATA_RD,
        DATA_WR
    } state_t;

    localparam logic [31:0] STAT_OFFSET = 32'h4;
    localparam logic [31:0] DATA_OFFSET = 32'h0;

    typedef struct packed {
        logic        cs;
        logic        as;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wr_data;
    } bus_req_t;

endpackage

// File: rtl/uart_bus_master_issuer.sv
// Single-transaction bus engine: as pulse, cs hold, timeout, done/err.
// Ports: start + start_{we,addr,wr_data} in, bus pins out, done/err out.
module bus_txn_issuer
    import uart_bus_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        start_we,
    input  logic [31:0] start_addr,
    input  logic [31:0] start_wr_data,
    input  logic        ready,
    output logic        cs,
    output logic        as,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wr_data,
    output logic        done,
    output logic        err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    bus_req_t        q;
    logic [TW-1:0]   tmo_cnt;

    assign cs      = q.cs;
    assign as      = q.as;
    assign we      = q.we;
    assign addr    = q.addr;
    assign wr_data = q.wr_data;

    // Completion is qualified by cs so stray ready pulses are ignored.
    assign done = q.cs & ready;

    // tmo_cnt holds the number of cs-high cycles including the current one,
    // so cs stays high for exactly TIMEOUT cycles before giving up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            err  <= 1'b0;
            q.as <= 1'b0;
            if (q.cs) begin
                if (ready) begin
                    q.cs    <= 1'b0;
                    tmo_cnt <= '0;
                end else if (tmo_cnt == TW'(TIMEOUT)) begin
                    q.cs    <= 1'b0;
                    err     <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else if (start) begin
                q.cs      <= 1'b1;
                q.as      <= 1'b1;
                q.we      <= start_we;
                q.addr    <= start_addr;
                q.wr_data <= start_wr_data;
                tmo_cnt   <= TW'(1);
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Byte-stream to UART register bus bridge: polls status, moves bytes.
// Ports: bus initiator pins, tx byte client (valid/accept), rx buffer, bus_err.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'hBFD0_03F8,
    parameter int          POLL_GAP         = 16,
    parameter int          TIMEOUT          = 1024,
    parameter int          STAT_TXIDLE_BIT  = 0,
    parameter int          STAT_RXAVAIL_BIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cs,
    output logic        as,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        ready,
    input  logic        tx_valid,
    input  logic [7:0]  tx_byte,
    output logic        tx_accept,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        bus_err
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

    state_t          state;
    logic [GW-1:0]   gap_cnt;
    logic            start;
    logic            req_we;
    logic [31:0]     req_addr;
    logic [31:0]     req_wr_data;
    logic            done;
    logic            err;
    logic            unused_rd;

    assign unused_rd = ^rd_data;
    assign bus_err   = err;

    bus_txn_issuer #(
        .TIMEOUT (TIMEOUT)
    ) u_issuer (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_we      (req_we),
        .start_addr    (req_addr),
        .start_wr_data (req_wr_data),
        .ready         (ready),
        .cs            (cs),
        .as            (as),
        .we            (we),
        .addr          (addr),
        .wr_data       (wr_data),
        .done          (done),
        .err           (err)
    );

    // start is a one-cycle request to the issuer, raised together with the
    // state change, so as appears one cycle after entering the issuing state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            start       <= 1'b0;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wr_data <= '0;
            tx_accept   <= 1'b0;
            rx_valid    <= 1'b0;
            rx_byte     <= '0;
        end else begin
            start     <= 1'b0;
            tx_accept <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_valid || tx_valid) begin
                        state       <= STAT;
                        start       <= 1'b1;
                        req_we      <= 1'b0;
                        req_addr    <= BASE_ADDR + STAT_OFFSET;
                        req_wr_data <= '0;
                    end
                end
                STAT: begin
                    if (done) begin
                        // RX first: draining the UART avoids receiver overrun.
                        if (rd_data[STAT_RXAVAIL_BIT] && !rx_valid) begin
                            state       <= DATA_RD;
                            start       <= 1'b1;
                            req_we      <= 1'b0;
                            req_addr    <= BASE_ADDR + DATA_OFFSET;
                            req_wr_data <= '0;
                        end else if (rd_data[STAT_TXIDLE_BIT] && tx_valid) begin
                            state       <= DATA_WR;
                            start       <= 1'b1;
                            req_we      <= 1'b1;
                            req_addr    <= BASE_ADDR + DATA_OFFSET;
                            req_wr_data <= {24'b0, tx_byte};
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GW'(POLL_GAP);
                        end
                    end else if (err) begin
                        state   <= GAP;
                        gap_cnt <= GW'(POLL_GAP);
                    end
                end
                DATA_RD: begin
                    if (done) begin
                        state    <= IDLE;
                        rx_byte  <= rd_data[7:0];
                        rx_valid <= 1'b1;
                    end else if (err) begin
                        state   <= GAP;
                        gap_cnt <= GW'(POLL_GAP);
                    end
                end
                DATA_WR: begin
                    if (done) begin
                        state     <= IDLE;
                        tx_accept <= 1'b1;
                    end else if (err) begin
                        // No accept: the client still holds the byte for retry.
                        state   <= GAP;
                        gap_cnt <= GW'(POLL_GAP);
                    end
                end
                GAP: begin
                    // Counts POLL_GAP cycles; a zero gap still spends one cycle.
                    if (gap_cnt <= GW'(1)) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master: responder model + scoreboard.
// Table-driven single-poll vectors plus hand sequences for multi-cycle cases.
module tb_uart_bus_master;

    localparam logic [31:0] BASE     = 32'hBFD0_03F8;
    localparam logic [31:0] STAT_A   = 32'hBFD0_03FC;
    localparam int          GAP_N    = 16;
    localparam int          TMO      = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs, as, we;
    logic [31:0] addr, wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_accept;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        bus_err;

    uart_bus_master #(
        .BASE_ADDR        (BASE),
        .POLL_GAP         (GAP_N),
        .TIMEOUT          (TMO),
        .STAT_TXIDLE_BIT  (0),
        .STAT_RXAVAIL_BIT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .as        (as),
        .we        (we),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .ready     (ready),
        .tx_valid  (tx_valid),
        .tx_byte   (tx_byte),
        .tx_accept (tx_accept),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .rx_ready  (rx_ready),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic [31:0] stat;
        logic        txv;
        logic [7:0]  txb;
        logic [31:0] data;
        int          kind;
        int          exp_acc;
        logic        exp_rxv;
        logic [7:0]  exp_rxb;
    } vec_t;

    txn_t        exp_q[$];
    int          as_log[$];
    int          done_log[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          acc_cnt  = 0;
    int          err_cnt  = 0;
    int          err_cyc  = 0;
    bit          strict   = 0;
    int          lat      = 1;
    int          r_cnt    = 0;
    bit          drop_wr  = 0;
    logic [31:0] stat_val = '0;
    logic [31:0] data_val = '0;
    logic        prev_as  = 1'b0;
    logic        prev_cs  = 1'b0;
    txn_t        e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_txn(input logic w, input logic [31:0] a,
                            input logic [31:0] d);
        txn_t t;
        t.we = w;
        t.addr = a;
        t.wdata = d;
        exp_q.push_back(t);
    endtask

    task automatic push_stat();
        push_txn(1'b0, STAT_A, 32'h0);
    endtask

    task automatic push_rd();
        push_txn(1'b0, BASE, 32'h0);
    endtask

    task automatic push_wr(input logic [7:0] b);
        push_txn(1'b1, BASE, {24'h0, b});
    endtask

    task automatic wait_q_empty(input int max, input string name);
        int k;
        for (k = 0; k < max && exp_q.size() != 0; k++) tick();
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        as_log.delete();
        done_log.delete();
        acc_cnt = 0;
        err_cnt = 0;
        rst = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    // Monitor + responder. ready is driven here for the cycle it is set in.
    always @(negedge clk) begin
        if (rst) begin
            ready   = 1'b0;
            rd_data = 32'hFFFF_FFFF;
            r_cnt   = 0;
            prev_as = 1'b0;
            prev_cs = 1'b0;
        end else begin
            if (as) begin
                as_log.push_back(cyc);
                check("cs_gap", {31'b0, prev_cs}, 32'h0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("txn_we", {31'b0, we}, {31'b0, e.we});
                    check("txn_addr", addr, e.addr);
                    check("txn_wdata", wr_data, e.wdata);
                end else if (strict) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL txn_unexpected: got addr %h we %b expected none",
                             addr, we);
                end
            end
            if (prev_as) check("as_pulse", {31'b0, as}, 32'h0);
            if (tx_accept) acc_cnt++;
            if (bus_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (cs && as) r_cnt = 0;
            else if (cs) r_cnt++;
            if (cs && r_cnt == lat && !(drop_wr && we)) begin
                ready   = 1'b1;
                rd_data = (addr == STAT_A) ? stat_val : data_val;
            end else begin
                ready   = 1'b0;
                rd_data = 32'hFFFF_FFFF;
            end
            if (cs && ready) done_log.push_back(cyc);
            prev_as = as;
            prev_cs = cs;
        end
    end

    initial begin
        vec_t vecs[8];
        int   k;
        int   n0;
        int   wr_as;

        vecs[0] = '{32'h0,         1'b0, 8'h00, 32'h0,   0, 0, 1'b0, 8'h00};
        vecs[1] = '{32'h2,         1'b0, 8'h00, 32'h41,  1, 0, 1'b1, 8'h41};
        vecs[2] = '{32'h1,         1'b1, 8'h5A, 32'h0,   2, 1, 1'b0, 8'h00};
        vecs[3] = '{32'h3,         1'b1, 8'h77, 32'h1C3, 1, 0, 1'b1, 8'hC3};
        vecs[4] = '{32'h1,         1'b0, 8'h00, 32'h0,   0, 0, 1'b0, 8'h00};
        vecs[5] = '{32'hFFFF_FFFC, 1'b1, 8'h11, 32'h0,   0, 0, 1'b0, 8'h00};
        vecs[6] = '{32'hFFFF_FFFD, 1'b1, 8'hA5, 32'h0,   2, 1, 1'b0, 8'h00};
        vecs[7] = '{32'h2,         1'b1, 8'h33, 32'h7E,  1, 0, 1'b1, 8'h7E};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        rx_ready = 1'b0;
        tick();
        check("rst_cs", {31'b0, cs}, 32'h0);
        check("rst_as", {31'b0, as}, 32'h0);
        check("rst_we", {31'b0, we}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_wdata", wr_data, 32'h0);
        check("rst_rx", {23'b0, rx_valid, rx_byte}, 32'h0);
        check("rst_pulses", {30'b0, tx_accept, bus_err}, 32'h0);
        do_reset();

        // Reset in the middle of a hung write.
        stat_val = 32'h1;
        drop_wr  = 1;
        tx_valid = 1'b1;
        tx_byte  = 8'hC4;
        strict   = 1;
        push_stat();
        push_wr(8'hC4);
        wait_q_empty(40, "rstmid_issue");
        repeat (5) tick();
        check("rstmid_inflight", {31'b0, cs}, 32'h1);
        rst = 1'b1;
        tick();
        check("rstmid_cs", {31'b0, cs}, 32'h0);
        tick();
        stat_val = 32'h0;
        drop_wr  = 0;
        exp_q.delete();
        push_stat();
        rst = 1'b0;
        wait_q_empty(20, "rstmid_first_stat");
        check("rstmid_no_accept", acc_cnt, 0);
        strict = 0;

        // Single-poll vectors, each from a fresh reset.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            stat_val = vecs[v].stat;
            data_val = vecs[v].data;
            tx_valid = vecs[v].txv;
            tx_byte  = vecs[v].txb;
            lat      = 1;
            strict   = 1;
            push_stat();
            if (vecs[v].kind == 1) push_rd();
            if (vecs[v].kind == 2) push_wr(vecs[v].txb);
            wait_q_empty(30, $sformatf("vec%0d_txns", v));
            repeat (3) tick();
            check($sformatf("vec%0d_acc", v), acc_cnt, vecs[v].exp_acc);
            check($sformatf("vec%0d_rxv", v), {31'b0, rx_valid},
                  {31'b0, vecs[v].exp_rxv});
            check($sformatf("vec%0d_rxb", v), {24'b0, rx_byte},
                  {24'b0, vecs[v].exp_rxb});
            strict = 0;
        end

        // RX path with slow responder, hold, consume, then poll gap.
        do_reset();
        tx_valid = 1'b0;
        lat      = 3;
        stat_val = 32'h2;
        data_val = 32'h0000_0041;
        strict   = 1;
        push_stat();
        push_rd();
        for (k = 0; k < 40 && !rx_valid; k++) tick();
        check("rx_valid_set", {31'b0, rx_valid}, 32'h1);
        check("rx_byte", {24'b0, rx_byte}, 32'h41);
        n0 = as_log.size();
        repeat (30) tick();
        check("rx_hold_no_txn", as_log.size(), n0);
        check("rx_hold_valid", {31'b0, rx_valid}, 32'h1);
        stat_val = 32'h0;
        as_log.delete();
        done_log.delete();
        push_stat();
        push_stat();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_clear", {31'b0, rx_valid}, 32'h0);
        wait_q_empty(80, "gap_polls");
        // GAP_N gap cycles plus the IDLE and issue cycles before as.
        if (as_log.size() >= 2 && done_log.size() >= 1)
            check("gap_len", as_log[1] - done_log[0] - 1, GAP_N + 2);
        else
            check("gap_logs", as_log.size(), 2);
        strict = 0;
        lat    = 1;

        // Status 3 with pending tx: read first, write after the next poll.
        do_reset();
        stat_val = 32'h3;
        data_val = 32'h0000_0005;
        tx_valid = 1'b1;
        tx_byte  = 8'h77;
        strict   = 1;
        push_stat();
        push_rd();
        push_stat();
        push_wr(8'h77);
        wait_q_empty(60, "prio_order");
        for (k = 0; k < 20 && acc_cnt == 0; k++) tick();
        tx_valid = 1'b0;
        strict   = 0;
        check("prio_acc", acc_cnt, 1);
        check("prio_rxb", {24'b0, rx_byte}, 32'h05);

        // Timeout on a write, then retry accepted once.
        do_reset();
        stat_val = 32'h1;
        tx_valid = 1'b1;
        tx_byte  = 8'h9C;
        drop_wr  = 1;
        strict   = 1;
        push_stat();
        push_wr(8'h9C);
        wait_q_empty(40, "tmo_issue");
        wr_as = (as_log.size() != 0) ? as_log[$] : 0;
        for (k = 0; k < TMO + 50 && err_cnt == 0; k++) tick();
        check("tmo_err_seen", err_cnt, 1);
        check("tmo_len", err_cyc - wr_as, TMO);
        check("tmo_cs_low", {31'b0, cs}, 32'h0);
        drop_wr = 0;
        push_stat();
        push_wr(8'h9C);
        tick();
        check("tmo_err_pulse", {31'b0, bus_err}, 32'h0);
        check("tmo_no_accept", acc_cnt, 0);
        for (k = 0; k < 100 && acc_cnt == 0; k++) tick();
        tx_valid = 1'b0;
        stat_val = 32'h0;
        strict   = 0;
        check("retry_queue", exp_q.size(), 0);
        repeat (40) tick();
        check("retry_acc_once", acc_cnt, 1);
        check("retry_err_once", err_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
